// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if -- instruction memory read bus between the fetch unit and imem.
//
// Signals:
//   imem_req    fetch unit -> imem : read request
//   imem_addr   fetch unit -> imem : word-aligned read address
//   imem_ack    imem -> fetch unit : read data valid this cycle
//   imem_rdata  imem -> fetch unit : instruction word
//
// Modports:
//   master : fetch unit side (drives request/address)
//   slave  : memory side (drives ack/data)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage.
//
// Requests one instruction word at a time from instruction memory, holds it
// (with its pc) until the decoder consumes it, then computes the next fetch
// address from the control-flow resolution presented with the handshake
// (sequential, jal/j, jr, bne). A request that waits IMEM_TIMEOUT cycles
// without imem_ack parks the unit in an error state until reset.
//
// Optional feature (macro FETCH_PREFETCH_EN): a one-entry prefetch register
// fetches the pc+4 word while an instruction is being held, so a sequential
// handshake can present the next instruction without another imem access.
// Default build (macro undefined): no prefetch.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   imem               fetch_unit_if.master (imem_req/addr out, ack/rdata in)
//   instr, pc          held instruction and its address
//   pc_plus4           pc + 4 (combinational), jal link value
//   instr_valid        instr/pc hold a fetched instruction
//   instr_ready        decoder consumes instr this cycle
//   resolve_valid, jmp, branch, branch_taken, imm16, target26, rs_val
//                      control-flow resolution for the consumed instruction
//   fetch_err          sticky imem_ack timeout flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    input  logic                resolve_valid,
    input  logic [1:0]          jmp,
    input  logic                branch,
    input  logic                branch_taken,
    input  logic [15:0]         imm16,
    input  logic [25:0]         target26,
    input  logic [31:0]         rs_val,
    output logic                fetch_err
);

    localparam int unsigned CNT_W = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [31:0]        fetch_pc_q,  fetch_pc_d;
    logic [31:0]        pc_q,        pc_d;
    logic [31:0]        instr_q,     instr_d;
    logic               valid_q,     valid_d;
    logic               err_q,       err_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               req_q,       req_d;
    logic [31:0]        addr_q,      addr_d;
`ifdef FETCH_PREFETCH_EN
    logic               pf_valid_q,  pf_valid_d;
    logic [31:0]        pf_data_q,   pf_data_d;
`endif

    logic               handshake_s;
    logic [31:0]        next_pc_s;
    logic [31:0]        br_off_s;

    assign pc_plus4    = pc_q + 32'd4;
    assign handshake_s = valid_q & instr_ready;
    assign br_off_s    = {{14{imm16[15]}}, imm16, 2'b00};

    // Next fetch address for the instruction being consumed; jumps win over bne.
    always_comb begin
        next_pc_s = pc_plus4;
        if (resolve_valid) begin
            case (jmp)
                2'b01, 2'b10: next_pc_s = {pc_plus4[31:28], target26, 2'b00};
                2'b11:        next_pc_s = rs_val & 32'hFFFF_FFFC;
                default: begin
                    if (branch && branch_taken) begin
                        next_pc_s = pc_plus4 + br_off_s;
                    end else begin
                        next_pc_s = pc_plus4;
                    end
                end
            endcase
        end else begin
            next_pc_s = pc_plus4;
        end
    end

    // FSM next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
`ifdef FETCH_PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_data_d  = pf_data_q;
`endif
        case (state_q)
            S_REQ: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    pc_d    = fetch_pc_q;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (handshake_s) begin
                    fetch_pc_d = next_pc_s;
`ifdef FETCH_PREFETCH_EN
                    // Sequential flow with the pc+4 word already captured:
                    // present it straight away, skipping the imem round trip.
                    if (pf_valid_q && (next_pc_s == pc_plus4)) begin
                        instr_d = pf_data_q;
                        pc_d    = pc_plus4;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        valid_d = 1'b0;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_REQ;
                    end
                    pf_valid_d = 1'b0;
`else
                    valid_d = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_REQ;
`endif
                end else begin
`ifdef FETCH_PREFETCH_EN
                    if (req_q && imem.imem_ack) begin
                        pf_valid_d = 1'b1;
                        pf_data_d  = imem.imem_rdata;
                    end else begin
                        pf_valid_d = pf_valid_q;
                    end
`endif
                    state_d = S_HOLD;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                // Unreachable encoding: park safely and flag it.
                valid_d = 1'b0;
                err_d   = 1'b1;
                state_d = S_ERR;
            end
        endcase
    end

    // Registered imem request/address derived from the next state.
    always_comb begin
        req_d  = 1'b0;
        addr_d = fetch_pc_d;
        if (state_d == S_REQ) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_d;
        end else begin
`ifdef FETCH_PREFETCH_EN
            if ((state_d == S_HOLD) && !pf_valid_d) begin
                req_d  = 1'b1;
                addr_d = pc_d + 32'd4;
            end else begin
                req_d  = 1'b0;
                addr_d = addr_q;
            end
`else
            req_d  = 1'b0;
            addr_d = addr_q;
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            req_q      <= 1'b1;
            addr_q     <= RESET_PC;
`ifdef FETCH_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_data_q  <= 32'h0000_0000;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
`ifdef FETCH_PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_data_q  <= pf_data_d;
`endif
        end
    end

    // req_q reloads to 1 under reset so the first post-reset cycle requests;
    // gating with rst_n keeps the bus quiet while reset is asserted.
    assign imem.imem_req  = req_q & rst_n;
    assign imem.imem_addr = addr_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign fetch_err      = err_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter: IMEM_TIMEOUT, 8, maximum wait cycles for imem_ack before the error flag sets.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned read address (bits [1:0] = 0).
REQ-007 imem_ack  input  1  read data valid this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 instr  output  32  held instruction; opcode = [31:26], func = [5:0] to decoder.
REQ-010 instr_valid  output  1  instr and pc hold a fetched instruction.
REQ-011 instr_ready  input  1  downstream consumes instr this cycle.
REQ-012 pc  output  32  address of instr.
REQ-013 pc_plus4  output  32  pc + 4, link value for jal.
REQ-014 resolve_valid  input  1  control-flow resolution for the consumed instruction.
REQ-015 jmp  input  2  00 none, 01 jal, 10 j, 11 jr.
REQ-016 branch  input  1  instruction is bne.
REQ-017 branch_taken  input  1  bne condition true (rs != rt).
REQ-018 imm16  input  16  branch offset, in words.
REQ-019 target26  input  26  jump target field.
REQ-020 rs_val  input  32  register value for jr.
REQ-021 fetch_err  output  1  sticky: imem_ack timeout.

Function
REQ-022 States: S_REQ (imem_req=1, await ack), S_HOLD (instr_valid=1, await instr_ready), S_ERR (all outputs frozen, imem_req=0).
REQ-023 S_REQ: imem_addr = fetch_pc; on imem_ack, latch imem_rdata into instr and fetch_pc into pc, then go to S_HOLD in the next cycle.
REQ-024 Fetch latency: imem_ack in cycle N -> instr_valid=1 in cycle N+1.
REQ-025 S_HOLD: instr, pc, and instr_valid stay stable until instr_ready=1; fetch_pc updates on the handshake, then go to S_REQ.
REQ-026 Next fetch_pc on handshake with resolve_valid=0, or with jmp=00 and branch=0: pc+4.
REQ-027 jmp=01 or jmp=10: {pc_plus4[31:28], target26, 2'b00}.
REQ-028 jmp=11: {rs_val[31:2], 2'b00}.
REQ-029 jmp=00, branch=1, branch_taken=1: pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}.
REQ-030 jmp=00, branch=1, branch_taken=0: pc+4.
REQ-031 jmp != 00 takes priority over branch.
REQ-032 No delay slot.
REQ-033 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-034 resolve_valid is ignored unless instr_valid & instr_ready.
REQ-035 imem_ack outside S_REQ is ignored.
REQ-036 Wait counter: reset on entering S_REQ; increments each S_REQ cycle without ack.
REQ-037 Counter reaching IMEM_TIMEOUT: go to S_ERR and set fetch_err; leave S_ERR only by reset.
REQ-038 pc_plus4 is combinational from pc.

Reset
REQ-039 While rst_n=0 at a rising edge: state=S_REQ, fetch_pc=RESET_PC, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, wait counter=0.
REQ-040 imem_req is forced 0 while rst_n=0.
REQ-041 Reset mid-transaction: a pending ack is discarded; the first request after reset is to RESET_PC.

Configuration
REQ-042 Macro FETCH_PREFETCH_EN defined: add a one-entry prefetch register holding the pc+4 word, fetched while in S_HOLD.
REQ-043 With FETCH_PREFETCH_EN, a handshake with no redirect and a valid prefetch entry gives instr_valid=1 on the next cycle with no imem access.
REQ-044 With FETCH_PREFETCH_EN, any redirect or reset invalidates the prefetch entry.
REQ-045 FETCH_PREFETCH_EN undefined: no prefetch, behaviour exactly per REQ-022..041.

Verification
REQ-046 Reset, then imem_ack=1 with rdata=32'h2408_0005 one cycle after the request -> imem_addr=0, instr=32'h2408_0005, pc=0, instr_valid=1 next cycle.
REQ-047 instr_ready held 0 for 5 cycles in S_HOLD -> instr and pc unchanged; imem_req=0 (prefetch off).
REQ-048 pc=32'h0000_0040, resolve jal with target26=26'h10 -> next imem_addr=32'h0000_0040, pc_plus4=32'h0000_0044.
REQ-049 pc=32'h100, bne taken with imm16=16'hFFFE -> next addr 32'hFC; same stimulus with branch_taken=0 -> next addr 32'h104.
REQ-050 jr with rs_val=32'h0000_1237 -> next addr 32'h0000_1234.
REQ-051 imem_ack held 0 for IMEM_TIMEOUT cycles -> fetch_err=1 and imem_req=0; rst_n=0 for one edge -> fetch_err=0, fetch restarts at RESET_PC.
